qam_mapper: RTL and testbench

//  Transmit-side constellation mapper; the bit-to-symbol stage whose I/Q output the receive-side

---
 rtl/qam_mapper_pkg.sv | 18 +
 rtl/qam_level_lut.sv | 12 +
 rtl/qam_mapper.sv | 88 ++++++++
 tb/tb_qam_mapper.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/qam_mapper_pkg.sv
// qam_mapper_pkg: constellation encodings and helpers shared by the QAM mapper and demapper.
package qam_mapper_pkg;
  localparam int SYM_W = 16;
  typedef enum logic [3:0] {
    MOD_BPSK = 4'd1, MOD_QPSK, MOD_8QAM, MOD_16QAM,
    MOD_32QAM, MOD_64QAM, MOD_128QAM, MOD_256QAM
  } mod_t;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  function automatic logic [5:0] k_split(input logic [3:0] m);
    return {3'((m + 4'd1) >> 1), 3'(m >> 1)};
  endfunction
  function automatic logic [3:0] gray2bin(input logic [3:0] g);
    return {g[3], ^g[3:2], ^g[3:1], ^g[3:0]};
  endfunction
  function automatic logic mod_ok(input logic [3:0] m);
    return m >= MOD_BPSK && m <= MOD_256QAM;
  endfunction
endpackage

// File: rtl/qam_level_lut.sv
// qam_level_lut: maps a k-bit Gray-coded axis index to its signed amplitude level.
module qam_level_lut
  import qam_mapper_pkg::*;
#(
  parameter int AMP = 2048
) (
  input  logic [2:0]       k,
  input  logic [3:0]       bits,
  output logic [SYM_W-1:0] level
);
  assign level = k == 3'd0 ? '0 : SYM_W'((2 * int'(gray2bin(bits)) - ((1 << k) - 1)) * AMP);
endmodule

// File: rtl/qam_mapper.sv
// qam_mapper: slices a byte frame into m-bit groups and emits Gray-coded rectangular-QAM {I,Q} symbols.
module qam_mapper
  import qam_mapper_pkg::*;
#(
  parameter int FRAME_BYTES = 31,
  parameter int AMP         = 2048
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mod_type,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  output logic        data_ready,
  output logic [31:0] sym_out,
  output logic        sym_valid,
  input  logic        sym_ready,
  output logic        busy,
  output logic        done,
  output logic        err
);
  localparam logic [7:0] FB = 8'(FRAME_BYTES);
  state_t state, state_nx;
  logic [15:0] bits, shifted, bits_nx;
  logic [4:0] cnt, cnt_t, cnt_nx;
  logic [7:0] bytes_in, grp;
  logic [3:0] m, gi, gq;
  logic [2:0] ki, kq;
  logic [SYM_W-1:0] lvl_i, lvl_q;
  logic load, take, out_free;
  assign {ki, kq} = k_split(m);
  // oldest bits sit at the top of the buffer; unused low bits are always zero, which gives the flush padding
  assign grp = bits[15:8] >> (4'd8 - m);
  assign gi = 4'(grp >> kq);
  assign gq = grp[3:0] & 4'((5'd1 << kq) - 5'd1);
  qam_level_lut #(.AMP(AMP)) u_lut_i (.k(ki), .bits(gi), .level(lvl_i));
  qam_level_lut #(.AMP(AMP)) u_lut_q (.k(kq), .bits(gq), .level(lvl_q));
  assign out_free   = ~sym_valid | sym_ready;
  assign data_ready = state == RUN && cnt <= 5'd8 && bytes_in < FB;
  assign load       = data_valid & data_ready;
  assign take       = out_free & (state == RUN ? cnt >= {1'b0, m} : state == FLUSH && cnt != 5'd0);
  assign busy       = state == RUN || state == FLUSH;
  assign done       = state == DONE;
  assign shifted    = take ? bits << m : bits;
  assign cnt_t      = take ? (cnt >= {1'b0, m} ? cnt - {1'b0, m} : 5'd0) : cnt;
  assign bits_nx    = shifted | (load ? {data_in, 8'h00} >> cnt_t : 16'h0);
  assign cnt_nx     = cnt_t + (load ? 5'd8 : 5'd0);
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  state_nx = start && mod_ok(mod_type) ? RUN : IDLE;
      RUN:   state_nx = bytes_in == FB && cnt < {1'b0, m} ? FLUSH : RUN;
      FLUSH: state_nx = cnt == 5'd0 && out_free ? DONE : FLUSH;
      DONE:  state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bits      <= '0;
      cnt       <= '0;
      bytes_in  <= '0;
      m         <= '0;
      sym_out   <= '0;
      sym_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= state_nx;
      err   <= state == IDLE && start && !mod_ok(mod_type);
      if (state == IDLE) begin
        if (start && mod_ok(mod_type)) begin
          m        <= mod_type;
          bits     <= '0;
          cnt      <= '0;
          bytes_in <= '0;
        end
      end else begin
        bits <= bits_nx;
        cnt  <= cnt_nx;
        if (load) bytes_in <= bytes_in + 8'd1;
      end
      if (take) begin
        sym_out   <= {lvl_i, lvl_q};
        sym_valid <= 1'b1;
      end else if (sym_ready) sym_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_qam_mapper.sv
// tb_qam_mapper: randomized frames checked against a bit-queue reference model of the QAM mapping rules.
module tb_qam_mapper;
  localparam int FB = 3;
  localparam int AMP = 2048;
  logic clk = 0, reset = 1, start = 0, data_valid = 0, sym_ready = 0;
  logic [3:0] mod_type = 0;
  logic [7:0] data_in = 0;
  logic data_ready, sym_valid, busy, done, err;
  logic [31:0] sym_out;
  int n_cmp = 0, n_bad = 0, done_cnt = 0;
  logic [31:0] rx[$];
  logic [31:0] exp_q[$];

  qam_mapper #(.FRAME_BYTES(FB), .AMP(AMP)) dut (
    .clk(clk), .reset(reset), .start(start), .mod_type(mod_type), .data_in(data_in),
    .data_valid(data_valid), .data_ready(data_ready), .sym_out(sym_out), .sym_valid(sym_valid),
    .sym_ready(sym_ready), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sym_valid && sym_ready) rx.push_back(sym_out);
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic int level(input int k, input int g);
    int b;
    if (k == 0) return 0;
    b = g;
    for (int s = 1; s < 4; s++) b = b ^ (g >> s);
    return (2 * b - (2 ** k - 1)) * AMP;
  endfunction

  task automatic model(input int m, input logic [7:0] frm[FB]);
    bit q[$];
    int ki, kq, vi, vq;
    logic [15:0] li, lq;
    exp_q.delete();
    for (int i = 0; i < FB; i++)
      for (int j = 7; j >= 0; j--) q.push_back(frm[i][j]);
    ki = (m + 1) / 2;
    kq = m / 2;
    while (q.size() > 0) begin
      vi = 0;
      vq = 0;
      for (int j = 0; j < ki; j++) vi = vi * 2 + (q.size() > 0 ? int'(q.pop_front()) : 0);
      for (int j = 0; j < kq; j++) vq = vq * 2 + (q.size() > 0 ? int'(q.pop_front()) : 0);
      li = 16'(level(ki, vi));
      lq = 16'(level(kq, vq));
      exp_q.push_back({li, lq});
    end
  endtask

  task automatic run_frame(input int m, input logic [7:0] b0, input bit stall);
    logic [7:0] frm[FB];
    logic [31:0] held;
    int bi, cyc;
    bit acc;
    frm[0] = b0;
    for (int i = 1; i < FB; i++) frm[i] = 8'($urandom);
    model(m, frm);
    rx.delete();
    done_cnt = 0;
    held = '0;
    start = 1;
    mod_type = 4'(m);
    @(posedge clk); #1;
    start = 0;
    bi = 0;
    cyc = 0;
    while (done_cnt == 0 && cyc < 3000) begin
      if (stall && cyc < 12) begin
        data_valid = bi < FB;
        sym_ready = 0;
      end else begin
        data_valid = bi < FB && $urandom_range(0, 3) != 0;
        sym_ready = $urandom_range(0, 3) != 0;
      end
      data_in = bi < FB ? frm[bi] : 8'h00;
      @(negedge clk);
      acc = data_valid && data_ready;
      if (stall && cyc == 2) held = sym_out;
      if (stall && cyc > 2 && cyc < 12) check("stall_hold", sym_out, held);
      if (stall && cyc == 11) begin
        check("stall_valid", 32'(sym_valid), 1);
        check("stall_ready_low", 32'(data_ready), 0);
      end
      @(posedge clk); #1;
      if (acc) bi++;
      cyc++;
    end
    data_valid = 0;
    sym_ready = 1;
    check($sformatf("done_m%0d", m), 32'(done_cnt), 1);
    check($sformatf("nsym_m%0d", m), 32'(rx.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx.size(); i++)
      check($sformatf("sym_m%0d_%0d", m, i), rx[i], exp_q[i]);
    @(negedge clk);
    check("idle_busy", {busy, done, sym_valid}, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_outs", {data_ready, sym_valid, busy, done, err}, 0);
    check("rst_sym", sym_out, 0);
    @(posedge clk); #1;
    reset = 0;
    sym_ready = 1;
    @(posedge clk); #1;

    run_frame(2, 8'hB4, 0);
    check("tv_b4_0", rx[0], 32'h0800F800);
    check("tv_b4_1", rx[1], 32'h08000800);
    check("tv_b4_2", rx[2], 32'hF8000800);
    check("tv_b4_3", rx[3], 32'hF800F800);
    run_frame(4, 8'h3C, 0);
    check("tv_3c_0", rx[0], 32'hE8000800);
    check("tv_3c_1", rx[1], 32'h0800E800);
    run_frame(3, 8'hFF, 0);
    run_frame(1, 8'hA5, 0);
    check("tv_a5_0", rx[0], 32'h08000000);
    check("tv_a5_1", rx[1], 32'hF8000000);
    run_frame(8, 8'h00, 0);
    check("tv_00_0", rx[0], 32'h88008800);
    run_frame(2, 8'h5A, 1);
    for (int r = 0; r < 10; r++) run_frame($urandom_range(1, 8), 8'($urandom), r % 4 == 0);
    for (int m = 1; m <= 8; m++) run_frame(m, 8'($urandom), 0);

    foreach (mod_type[i]) begin end
    start = 1;
    mod_type = 0;
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    check("err_m0", {err, busy}, 2'b10);
    @(posedge clk); #1;
    start = 1;
    mod_type = 9;
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    check("err_m9", {err, busy}, 2'b10);
    @(posedge clk); #1;
    @(negedge clk);
    check("err_clear", {err, busy}, 0);
    @(posedge clk); #1;

    done_cnt = 0;
    start = 1;
    mod_type = 4;
    @(posedge clk); #1;
    start = 0;
    data_valid = 1;
    data_in = 8'hC3;
    sym_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    data_valid = 0;
    @(negedge clk);
    check("mid_busy", 32'(busy), 1);
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    check("abort_outs", {data_ready, sym_valid, busy, done, err}, 0);
    check("abort_sym", sym_out, 0);
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt), 0);

    sym_ready = 1;
    run_frame(5, 8'($urandom), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
